updown_counter_n: RTL and testbench

Parametrised synchronous up/down counter: the fully clocked, generalised successor to the 4-bit ripple up/down counter. It counts in either direction on a single clock, with configurable width, modulus and wrap-or-saturate mode, plus parallel load, count enable and terminal-count/wrap flags. It serves as a general counter and divider primitive for the Counters library, e.g. decade counters, timers and address generators.

---
 rtl/updown_counter_n.sv | 83 ++++++++
 tb/tb_updown_counter_n.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/updown_counter_n.sv
// Parametrised synchronous up/down counter with modulus, wrap-or-saturate mode,
// parallel load (clamped to MAX_VAL), terminal-count, wrap and saturation flags.
module updown_counter_n #(
    parameter int unsigned          WIDTH    = 4,
    parameter logic [WIDTH-1:0]     MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                   SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Count,
    output logic             tc,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             at_limit_next;
    logic [WIDTH-1:0] limit;

    // Next-state: load beats counting; limits either wrap or hold
    always_comb begin
        count_next    = Count;
        wrap_next     = 1'b0;
        at_limit_next = 1'b0;
        limit         = up_down ? MAX_VAL : ZERO;

        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_down) begin
                if (Count >= MAX_VAL) begin
                    if (SATURATE) begin
                        count_next = MAX_VAL;
                    end else begin
                        count_next = ZERO;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = Count + ONE;
                end
            end else begin
                if (Count == ZERO) begin
                    if (SATURATE) begin
                        count_next = ZERO;
                    end else begin
                        count_next = MAX_VAL;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = Count - ONE;
                end
            end
        end

        if (SATURATE && (count_next == limit)) begin
            at_limit_next = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            Count    <= ZERO;
            wrap     <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            Count    <= count_next;
            wrap     <= wrap_next;
            at_limit <= at_limit_next;
        end
    end

    // Terminal count follows direction with no clock delay
    assign tc = (up_down && (Count == MAX_VAL)) || (!up_down && (Count == ZERO));

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: three instances (default, mod-10 wrap,
// mod-10 saturate) share inputs; each vector checks one instance.
module tb_updown_counter_n;

    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DC = 2;

    logic       Clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       tc_a, tc_b, tc_c;
    logic       wr_a, wr_b, wr_c;
    logic       lim_a, lim_b, lim_c;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    updown_counter_n #(.WIDTH(4)) u_a (
        .Clk(Clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .Count(cnt_a), .tc(tc_a), .wrap(wr_a), .at_limit(lim_a)
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_b (
        .Clk(Clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .Count(cnt_b), .tc(tc_b), .wrap(wr_b), .at_limit(lim_b)
    );

    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_c (
        .Clk(Clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .Count(cnt_c), .tc(tc_c), .wrap(wr_c), .at_limit(lim_c)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ud;
        logic       ld;
        logic [3:0] lval;
        int         dut;
        logic [3:0] cnt;
        logic       tc;
        logic       wr;
        logic       lim;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic e, input logic u,
                                input logic l, input logic [3:0] lv, input int d,
                                input logic [3:0] c, input logic t, input logic w,
                                input logic lm);
        vec_t v;
        v = '{rst: r, en: e, ud: u, ld: l, lval: lv, dut: d, cnt: c, tc: t, wr: w, lim: lm};
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic check_dut(input int idx, input int d, input logic [3:0] c,
                             input logic t, input logic w, input logic lm);
        logic [3:0] gc;
        logic       gt, gw, gl;
        case (d)
            DA:      begin gc = cnt_a; gt = tc_a; gw = wr_a; gl = lim_a; end
            DB:      begin gc = cnt_b; gt = tc_b; gw = wr_b; gl = lim_b; end
            default: begin gc = cnt_c; gt = tc_c; gw = wr_c; gl = lim_c; end
        endcase
        check($sformatf("dut%0d count", d), idx, int'(gc), int'(c));
        check($sformatf("dut%0d tc", d), idx, int'(gt), int'(t));
        check($sformatf("dut%0d wrap", d), idx, int'(gw), int'(w));
        check($sformatf("dut%0d at_limit", d), idx, int'(gl), int'(lm));
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        @(negedge Clk);
        rst = r; en = e; up_down = u; load = l; load_val = lv;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int c;

        // Default 4-bit: reset then count up 17 cycles through the wrap
        add(1, 0, 1, 0, 4'd0, DA, 4'd0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            c = k % 16;
            add(0, 1, 1, 0, 4'd0, DA, 4'(c), c == 15, c == 0, 0);
        end

        // Mod-10 wrap: count down from reset, wrap back up, load clamp, load beats en
        add(1, 0, 0, 0, 4'd0, DB, 4'd0, 1, 0, 0);
        for (int k = 0; k <= 10; k++) begin
            c = (k == 10) ? 9 : 9 - k;
            add(0, 1, 0, 0, 4'd0, DB, 4'(c), c == 0, c == 9, 0);
        end
        add(0, 1, 1, 0, 4'd0, DB, 4'd0, 0, 1, 0);
        add(0, 0, 1, 0, 4'd0, DB, 4'd0, 0, 0, 0);
        add(0, 0, 1, 1, 4'd12, DB, 4'd9, 1, 0, 0);
        add(0, 1, 1, 1, 4'd5, DB, 4'd5, 0, 0, 0);

        // Mod-10 saturate: climb from 7 and stick, turn down, stick at 0
        add(1, 0, 1, 0, 4'd0, DC, 4'd0, 0, 0, 0);
        add(0, 0, 1, 1, 4'd7, DC, 4'd7, 0, 0, 0);
        add(0, 1, 1, 0, 4'd0, DC, 4'd8, 0, 0, 0);
        add(0, 1, 1, 0, 4'd0, DC, 4'd9, 1, 0, 1);
        add(0, 1, 1, 0, 4'd0, DC, 4'd9, 1, 0, 1);
        add(0, 1, 1, 0, 4'd0, DC, 4'd9, 1, 0, 1);
        add(0, 1, 0, 0, 4'd0, DC, 4'd8, 0, 0, 0);
        add(0, 0, 0, 1, 4'd1, DC, 4'd1, 0, 0, 0);
        add(0, 1, 0, 0, 4'd0, DC, 4'd0, 1, 0, 1);
        add(0, 1, 0, 0, 4'd0, DC, 4'd0, 1, 0, 1);
        add(0, 0, 1, 1, 4'd9, DC, 4'd9, 1, 0, 1);

        // Mid-run reset with load and en high, then freeze with en low
        add(0, 0, 1, 1, 4'd6, DC, 4'd6, 0, 0, 0);
        add(1, 1, 1, 1, 4'd3, DC, 4'd0, 0, 0, 0);
        add(0, 1, 1, 0, 4'd0, DC, 4'd1, 0, 0, 0);
        add(0, 0, 1, 0, 4'd0, DC, 4'd1, 0, 0, 0);
        add(0, 0, 1, 0, 4'd0, DC, 4'd1, 0, 0, 0);
        add(0, 0, 1, 0, 4'd0, DC, 4'd1, 0, 0, 0);

        // Direction toggling every cycle from 3
        add(1, 0, 1, 0, 4'd0, DB, 4'd0, 0, 0, 0);
        add(0, 0, 1, 1, 4'd3, DB, 4'd3, 0, 0, 0);
        add(0, 1, 1, 0, 4'd0, DB, 4'd4, 0, 0, 0);
        add(0, 1, 0, 0, 4'd0, DB, 4'd3, 0, 0, 0);
        add(0, 1, 1, 0, 4'd0, DB, 4'd4, 0, 0, 0);
        add(0, 1, 0, 0, 4'd0, DB, 4'd3, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].en, vq[i].ud, vq[i].ld, vq[i].lval);
            check_dut(i, vq[i].dut, vq[i].cnt, vq[i].tc, vq[i].wr, vq[i].lim);
        end

        // tc follows up_down with no clock edge, at 0 and at MAX_VAL
        drive(0, 0, 0, 1, 4'd0);
        check("tc at zero down", 100, int'(tc_b), 1);
        @(negedge Clk); load = 1'b0; up_down = 1'b1; #1;
        check("tc at zero up", 101, int'(tc_b), 0);
        up_down = 1'b0; #1;
        check("tc at zero down again", 102, int'(tc_b), 1);
        drive(0, 0, 1, 1, 4'd9);
        check("tc at max up", 103, int'(tc_b), 1);
        @(negedge Clk); load = 1'b0; up_down = 1'b0; #1;
        check("tc at max down", 104, int'(tc_b), 0);
        up_down = 1'b1; #1;
        check("tc at max up again", 105, int'(tc_b), 1);
        check("count held at max", 106, int'(cnt_b), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
